// File: rtl/clock_control_logic_out_multi.sv
// Output clock-control node: merges child requests into one parent request and runs the
// enable/ack handshake with a leaf clock gate, with stop debounce, ack timeout and sticky fault.
module clock_control_logic_out_multi #(
    parameter int NUM_CHILDREN = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 4,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    parent_request,
    input  logic                    parent_ready,
    input  logic                    parent_silent,
    input  logic                    parent_stopping,
    input  logic [NUM_CHILDREN-1:0] child_request,
    output logic [NUM_CHILDREN-1:0] child_ready,
    output logic                    child_silent,
    output logic                    child_starting,
    output logic                    child_stopping,
    output logic                    async_enable,
    input  logic                    async_enable_ack,
    input  logic                    fault_clear,
    output logic                    fault
);

    localparam int IDLE_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TMO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        ST_STOPPED,
        ST_STARTING,
        ST_RUNNING,
        ST_STOPPING,
        ST_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                async_enable_q, async_enable_d;
    logic                fault_q, fault_d;

    logic ack_s, any_req, go, parent_lost, tmo, handshaking;

    assign ack_s       = sync_q[SYNC_STAGES-1];
    assign any_req     = |child_request;
    assign go          = any_req & parent_ready & ~parent_stopping;
    assign parent_lost = parent_stopping | ~parent_ready;
    assign tmo         = (ACK_TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);
    assign handshaking = (state_q == ST_STARTING) || (state_q == ST_STOPPING);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            ST_STOPPED:  if (go) state_d = ST_STARTING;
            ST_STARTING: begin
                if (parent_lost)  state_d = ST_STOPPING;
                else if (ack_s)   state_d = ST_RUNNING;
                else if (tmo)     state_d = ST_FAULT;
            end
            ST_RUNNING: begin
                if (parent_lost)                              state_d = ST_STOPPING;
                else if ((idle_cnt_q == IDLE_LAST) && !any_req) state_d = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (!ack_s)       state_d = ST_STOPPED;
                else if (tmo)     state_d = ST_FAULT;
            end
            ST_FAULT:    if (fault_clear && !ack_s) state_d = ST_STOPPED;
            default:     state_d = ST_STOPPED;
        endcase
    end

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_enable_ack};

        // Idle count only advances in RUNNING; saturation makes the stop test a single compare.
        idle_cnt_d = idle_cnt_q;
        if (((state_d == ST_RUNNING) && (state_q != ST_RUNNING)) || any_req) begin
            idle_cnt_d = '0;
        end else if ((state_q == ST_RUNNING) && (idle_cnt_q != IDLE_LAST)) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end

        tmo_cnt_d = tmo_cnt_q;
        if ((state_d != state_q) && ((state_d == ST_STARTING) || (state_d == ST_STOPPING))) begin
            tmo_cnt_d = '0;
        end else if (handshaking) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        async_enable_d = (state_d == ST_STARTING) || (state_d == ST_RUNNING);
        fault_d        = (state_d == ST_FAULT);
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q        <= ST_STOPPED;
            sync_q         <= '0;
            idle_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            async_enable_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            idle_cnt_q     <= idle_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            async_enable_q <= async_enable_d;
            fault_q        <= fault_d;
        end
    end

    assign parent_request = any_req | ((state_q != ST_STOPPED) && (state_q != ST_FAULT));
    assign child_ready    = {NUM_CHILDREN{parent_ready && (state_q == ST_RUNNING)}} & child_request;
    assign child_silent   = parent_silent | (state_q == ST_STOPPED) | (state_q == ST_FAULT);
    assign child_starting = (state_q == ST_STARTING);
    assign child_stopping = (state_q == ST_STOPPING);
    assign async_enable   = async_enable_q;
    assign fault          = fault_q;

endmodule

// File: tb/tb_clock_control_logic_out_multi.sv
// Directed bench for clock_control_logic_out_multi; the clock gate is modelled as an ack that
// mirrors async_enable three cycles later, with an override that holds it low.
module tb_clock_control_logic_out_multi;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       parent_request;
    logic       parent_ready = 1'b0;
    logic       parent_silent = 1'b0;
    logic       parent_stopping = 1'b0;
    logic [3:0] child_request = 4'b0000;
    logic [3:0] child_ready;
    logic       child_silent, child_starting, child_stopping;
    logic       async_enable;
    logic       async_enable_ack;
    logic       fault_clear = 1'b0;
    logic       fault;

    logic [2:0] ack_pipe = 3'b000;
    logic       ack_hold_low = 1'b0;

    int checks = 0;
    int errors = 0;

    // {parent_request, fault, async_enable, child_stopping, child_starting, child_silent}
    logic [5:0] status;
    localparam logic [5:0] S_IDLE      = 6'b000001;
    localparam logic [5:0] S_STOP_REQ  = 6'b100001;
    localparam logic [5:0] S_STARTING  = 6'b101010;
    localparam logic [5:0] S_RUNNING   = 6'b101000;
    localparam logic [5:0] S_STOPPING  = 6'b100100;
    localparam logic [5:0] S_FAULT_REQ = 6'b110001;
    localparam logic [5:0] S_FAULT     = 6'b010001;

    always #5 clock = ~clock;

    always @(posedge clock) ack_pipe <= {ack_pipe[1:0], async_enable};
    assign async_enable_ack = ack_pipe[2] & ~ack_hold_low;

    assign status = {parent_request, fault, async_enable, child_stopping, child_starting, child_silent};

    clock_control_logic_out_multi #(
        .NUM_CHILDREN(4),
        .SYNC_STAGES (2),
        .HOLD_CYCLES (4),
        .ACK_TIMEOUT (64)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .parent_request  (parent_request),
        .parent_ready    (parent_ready),
        .parent_silent   (parent_silent),
        .parent_stopping (parent_stopping),
        .child_request   (child_request),
        .child_ready     (child_ready),
        .child_silent    (child_silent),
        .child_starting  (child_starting),
        .child_stopping  (child_stopping),
        .async_enable    (async_enable),
        .async_enable_ack(async_enable_ack),
        .fault_clear     (fault_clear),
        .fault           (fault)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_status(input string tag, input logic [5:0] expected, input int max_cycles);
        int n = 0;
        while ((status !== expected) && (n < max_cycles)) begin
            tick();
            n++;
        end
        check(tag, status, expected);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset behaviour
        tick_n(3);
        check("reset_status", status, S_IDLE);
        check("reset_child_ready", child_ready, 4'b0000);
        child_request = 4'b0100;
        #1;
        check("reset_parent_req", status, S_STOP_REQ);
        child_request = 4'b0000;
        reset = 1'b0;
        parent_ready = 1'b1;
        tick();
        check("idle_after_reset", status, S_IDLE);

        // 1: single request, full start/stop handshake with exact latencies
        child_request = 4'b0001;
        tick();
        check("t1_enable_next_edge", status, S_STARTING);
        tick_n(5);
        check("t1_still_starting", status, S_STARTING);
        tick();
        check("t1_running", status, S_RUNNING);
        check("t1_child_ready", child_ready, 4'b0001);
        tick_n(2);
        child_request = 4'b0000;
        #1;
        check("t1_ready_follows_req", child_ready, 4'b0000);
        tick_n(3);
        check("t1_hold_running", status, S_RUNNING);
        tick();
        check("t1_stopping_after_4_idle", status, S_STOPPING);
        tick_n(5);
        check("t1_wait_ack_low", status, S_STOPPING);
        tick();
        check("t1_stopped", status, S_IDLE);

        // 2: periodic short requests never let the hold expire
        child_request = 4'b0010;
        tick();
        check("t2_starting", status, S_STARTING);
        tick_n(6);
        check("t2_running", status, S_RUNNING);
        check("t2_child_ready", child_ready, 4'b0010);
        parent_silent = 1'b1;
        #1;
        check("t2_parent_silent", child_silent, 1'b1);
        parent_silent = 1'b0;
        for (int i = 0; i < 6; i++) begin
            child_request = 4'b0010;
            #1;
            check($sformatf("t2_ready_pulse%0d", i), child_ready, 4'b0010);
            tick();
            child_request = 4'b0000;
            #1;
            check($sformatf("t2_keep_running%0d", i), status, S_RUNNING);
            tick_n(2);
        end
        tick();
        check("t2_last_hold_cycle", status, S_RUNNING);
        tick();
        check("t2_stop_after_hold", status, S_STOPPING);
        wait_status("t2_stopped", S_IDLE, 12);

        // 3: ack never arrives -> timeout into sticky fault
        ack_hold_low = 1'b1;
        child_request = 4'b0001;
        tick();
        check("t3_starting", status, S_STARTING);
        tick_n(63);
        check("t3_pre_timeout", status, S_STARTING);
        tick();
        check("t3_fault", status, S_FAULT_REQ);
        child_request = 4'b0000;
        tick();
        check("t3_fault_sticky", status, S_FAULT);
        fault_clear = 1'b1;
        tick();
        check("t3_cleared", status, S_IDLE);
        fault_clear = 1'b0;
        tick_n(4);
        ack_hold_low = 1'b0;
        tick_n(4);
        check("t3_idle_after_release", status, S_IDLE);

        // 4: parent stopping aborts a start
        child_request = 4'b0001;
        tick();
        check("t4_starting", status, S_STARTING);
        parent_stopping = 1'b1;
        tick();
        check("t4_abort_to_stopping", status, S_STOPPING);
        check("t4_no_child_ready", child_ready, 4'b0000);
        tick();
        check("t4_stopped", status, S_STOP_REQ);
        child_request = 4'b0000;
        parent_stopping = 1'b0;
        tick_n(8);
        check("t4_idle", status, S_IDLE);

        // 5: request during STOPPING waits for the stop to finish
        child_request = 4'b0001;
        wait_status("t5_running", S_RUNNING, 20);
        child_request = 4'b0000;
        wait_status("t5_stopping", S_STOPPING, 10);
        child_request = 4'b0001;
        tick_n(5);
        check("t5_hold_stopping", status, S_STOPPING);
        tick();
        check("t5_stopped_one_cycle", status, S_STOP_REQ);
        tick();
        check("t5_restart", status, S_STARTING);

        // 6: parent loss bypasses hold, then reset while running
        wait_status("t6_running", S_RUNNING, 20);
        parent_ready = 1'b0;
        #1;
        check("t6_ready_drops", child_ready, 4'b0000);
        tick();
        check("t6_parent_loss", status, S_STOPPING);
        parent_ready = 1'b1;
        wait_status("t6_restart", S_RUNNING, 30);
        reset = 1'b1;
        tick();
        check("t6_reset", status, S_STOP_REQ);
        check("t6_reset_ready", child_ready, 4'b0000);
        child_request = 4'b0000;
        tick_n(2);
        reset = 1'b0;
        tick_n(6);
        check("t6_after_reset", status, S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
